// File: rtl/mem_access_stage_if.sv
// EX/MEM -> MEM stage bundle: pipeline inputs from execute,
// branch resolution back to fetch and MEM/WB outputs.
interface mem_access_stage_if #(
  parameter int WORD = 32
);
  logic [WORD-1:0] Branch_Target;
  logic [WORD-1:0] Result;
  logic [WORD-1:0] MemWriteData;
  logic [4:0]      RegDstAddress;
  logic            zero;
  logic            Branch;
  logic            MemRead;
  logic            MemWrite;
  logic            RegWrite_in;
  logic            MemtoReg_in;

  logic            PCSrc;
  logic [WORD-1:0] Branch_Target_out;
  logic [WORD-1:0] ReadData;
  logic [WORD-1:0] ALUResult;
  logic [4:0]      RegDstAddress_out;
  logic            RegWrite_out;
  logic            MemtoReg_out;

  modport master (
    output Branch_Target, Result, MemWriteData,
    output RegDstAddress, zero, Branch,
    output MemRead, MemWrite,
    output RegWrite_in, MemtoReg_in,
    input  PCSrc, Branch_Target_out,
    input  ReadData, ALUResult,
    input  RegDstAddress_out,
    input  RegWrite_out, MemtoReg_out
  );

  modport slave (
    input  Branch_Target, Result, MemWriteData,
    input  RegDstAddress, zero, Branch,
    input  MemRead, MemWrite,
    input  RegWrite_in, MemtoReg_in,
    output PCSrc, Branch_Target_out,
    output ReadData, ALUResult,
    output RegDstAddress_out,
    output RegWrite_out, MemtoReg_out
  );
endinterface

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: branch resolve, word load/store on local
// data memory, and the MEM/WB pipeline buffer.
module mem_access_stage #(
  parameter int WORD      = 32,
  parameter int ADDR_BITS = 8
) (
  input logic               clk,
  input logic               reset,
  mem_access_stage_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WORD-1:0]      mem [DEPTH];
  logic [ADDR_BITS-1:0] index;
  logic [WORD-1:0]      rd_word;

  logic [WORD-1:0] read_q;
  logic [WORD-1:0] alu_q;
  logic [4:0]      dst_q;
  logic            regwr_q;
  logic            m2r_q;

  // Byte offset and high address bits are dropped: word
  // addressing that wraps over the memory depth.
  logic unused_addr;
  assign unused_addr = ^{bus.Result[WORD-1:ADDR_BITS+2],
                         bus.Result[1:0]};

  assign index   = bus.Result[ADDR_BITS+1:2];
  assign rd_word = mem[index];

  assign bus.PCSrc             = bus.Branch & bus.zero;
  assign bus.Branch_Target_out = bus.Branch_Target;

  always_ff @(posedge clk) begin
    if (reset && bus.MemWrite)
      mem[index] <= bus.MemWriteData;
  end

  // rd_word is sampled before the store lands: read-before-write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_q  <= '0;
      alu_q   <= '0;
      dst_q   <= '0;
      regwr_q <= 1'b0;
      m2r_q   <= 1'b0;
    end else begin
      read_q  <= bus.MemRead ? rd_word : '0;
      alu_q   <= bus.Result;
      dst_q   <= bus.RegDstAddress;
      regwr_q <= bus.RegWrite_in;
      m2r_q   <= bus.MemtoReg_in;
    end
  end

  assign bus.ReadData          = read_q;
  assign bus.ALUResult         = alu_q;
  assign bus.RegDstAddress_out = dst_q;
  assign bus.RegWrite_out      = regwr_q;
  assign bus.MemtoReg_out      = m2r_q;
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (MEM) stage of the five-stage MIPS pipeline, directly downstream of the execute stage and its EX/MEM buffer. It takes the EX/MEM register outputs, resolves the branch decision for fetch, and performs word loads and stores on a local synchronous-write data memory. It also registers load data, the ALU result and the write-back controls into the MEM/WB pipeline buffer for the write-back stage.

## Interface
- `WORD`, 32: data/address width (the codebase `WORD` define).
- `ADDR_BITS`, 8: word-index width; memory depth is 2^ADDR_BITS words (256).

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `Branch_Target`  in  WORD  branch target from EX/MEM.
- `Result`  in  WORD  ALU result / memory byte address from EX/MEM.
- `MemWriteData`  in  WORD  store data from EX/MEM.
- `RegDstAddress`  in  5  destination register from EX/MEM.
- `zero`  in  1  ALU zero flag from EX/MEM.
- `Branch`, `MemRead`, `MemWrite`, `RegWrite_in`, `MemtoReg_in`  in  1 each  control from EX/MEM.
- `PCSrc`  out  1  take-branch select to fetch (combinational).
- `Branch_Target_out`  out  WORD  pass-through of `Branch_Target` to fetch (combinational).
- `ReadData`  out  WORD  MEM/WB: loaded word.
- `ALUResult`  out  WORD  MEM/WB: registered `Result`.
- `RegDstAddress_out`  out  5  MEM/WB: registered destination.
- `RegWrite_out`, `MemtoReg_out`  out  1 each  MEM/WB: registered controls.

## Operation
- Branch resolution: `PCSrc = Branch & zero`; `Branch_Target_out = Branch_Target`. Pure combinational, no state.
- Addressing: word index = `Result[ADDR_BITS+1:2]`. `Result[1:0]` is ignored (no misalignment trap). Bits above `ADDR_BITS+1` are ignored, so addresses wrap modulo 2^ADDR_BITS words.
- Store: on the rising edge with `MemWrite`=1 and `reset`=1, write `MemWriteData` to mem[index]. No write occurs while `reset`=0.
- Load: the memory is read combinationally at the index. On the rising edge, `ReadData` loads mem[index] if `MemRead`=1, otherwise 0.
- Simultaneous `MemRead`=1 and `MemWrite`=1 (illegal from the decoder, but defined): the write is performed and `ReadData` captures the old (pre-write) word. This is read-before-write.
- MEM/WB buffer: on every rising edge out of reset, `ALUResult`←`Result`, `RegDstAddress_out`←`RegDstAddress`, `RegWrite_out`←`RegWrite_in`, `MemtoReg_out`←`MemtoReg_in`, `ReadData` as above. There is no stall or flush input; the buffer loads every cycle.
- Reset (`reset`=0, any time, asynchronous): all MEM/WB outputs go to 0 immediately, without waiting for a clock. Memory contents are not cleared and are retained across reset. Combinational outputs keep following their inputs during reset.

## Timing
- `PCSrc` / `Branch_Target_out`: 0-cycle latency, same cycle as the EX/MEM values.
- MEM/WB outputs: 1-cycle latency, registered on the edge that ends the MEM cycle.
- Store-then-load to the same word in back-to-back cycles: the load returns the new data, because the write lands on edge N and the read in cycle N+1 sees it.
- Reset deassertion: the first capture is on the first rising edge with `reset`=1. A write presented while `reset`=0 is lost.
- Reset asserted mid-stream: outputs are cleared within the same cycle, and a store in flight on that edge is suppressed.

## Test plan
- Store/load: cycle 0 SW `Result`=0x10, `MemWriteData`=0xDEADBEEF, `MemWrite`=1. Cycle 1 LW `Result`=0x10, `MemRead`=1 → after edge `ReadData`=0xDEADBEEF, `ALUResult`=0x10.
- Wrap and byte-offset: store 0x12345678 at `Result`=0x400. Load from `Result`=0x003 → 0x12345678; load from 0x000 with `MemRead`=0 → `ReadData`=0.
- Branch: `Branch`=1, `zero`=1, `Branch_Target`=0x40 → `PCSrc`=1 and `Branch_Target_out`=0x40 in the same cycle. Set `zero`=0 → `PCSrc`=0.
- Read+write collision: mem[5]=0xAAAA; present `Result`=0x14, `MemRead`=`MemWrite`=1, data 0xBBBB → `ReadData`=0xAAAA; next load of 0x14 → 0xBBBB.
- Pass-through: `RegDstAddress`=17, `RegWrite_in`=1, `MemtoReg_in`=1 → one edge later the outputs are 17, 1, 1.
- Async reset: with outputs nonzero, drop `reset` mid-cycle → all MEM/WB outputs 0 before the next edge. Present a store to 0x20 during reset → after release, a load of 0x20 returns the prior contents.
